// File: rtl/alarm_channel_scheduler.sv
// Multi-channel countdown alarm scheduler: NUM_CH centisecond alarms share one decrementer
// that sweeps the channels once per tick; debounced button commands act on the selected channel.
module alarm_channel_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100,
  parameter int WIDTH   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [$clog2(NUM_CH)-1:0] sel,
  input  logic [8:0]                load_val,
  input  logic                      btn_load,
  input  logic                      btn_startstop,
  input  logic                      btn_clear,
  output logic [WIDTH-1:0]          disp_value,
  output logic                      disp_flash,
  output logic                      buzzer_on,
  output logic [NUM_CH-1:0]         running,
  output logic [NUM_CH-1:0]         expired
);
  localparam int PW    = $clog2(NUM_CH);
  localparam int PRESC = CLK_HZ / TICK_HZ;
  localparam int CW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [CW-1:0]    PRESC_LAST = CW'(PRESC - 1);
  localparam logic [PW-1:0]    P_LAST     = PW'(NUM_CH - 1);
  localparam logic [WIDTH-1:0] CS_PER_S   = WIDTH'(100);
  localparam int B_SS  = 0;
  localparam int B_LD  = 1;
  localparam int B_CLR = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, EXPIRED = 2'd3} ch_state_e;

  if (PRESC < NUM_CH + 1) begin : g_presc_check
    $error("CLK_HZ/TICK_HZ must be at least NUM_CH+1 so each sweep ends before the next tick");
  end

  logic [2:0]       btn_raw_s;
  logic [2:0]       sync1_q, sync2_q, hist_q, armed_q, armed_d, press_s;
  logic [1:0]       settle_q, settle_d;
  logic             settle_done_s;
  logic [CW-1:0]    presc_q;
  logic             tick_s;
  logic             sweep_q;
  logic [PW-1:0]    p_q;
  logic [WIDTH-1:0] cnt_q [NUM_CH];
  logic [WIDTH-1:0] cnt_d [NUM_CH];
  ch_state_e        st_q  [NUM_CH];
  ch_state_e        st_d  [NUM_CH];
  logic [WIDTH-1:0] load_cs_s;
  logic [WIDTH-1:0] disp_value_q, disp_value_d;
  logic             disp_flash_q, disp_flash_d, buzzer_on_q, buzzer_on_d;
  logic [NUM_CH-1:0] running_q, running_d, expired_q, expired_d;

  assign btn_raw_s = {btn_clear, btn_load, btn_startstop};

  // Button synchroniser, history sample and post-reset settle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 3'b111;
      sync2_q  <= 3'b111;
      hist_q   <= 3'b111;
      armed_q  <= 3'b000;
      settle_q <= 2'd0;
    end else begin
      sync1_q  <= btn_raw_s;
      sync2_q  <= sync1_q;
      hist_q   <= sync2_q;
      armed_q  <= armed_d;
      settle_q <= settle_d;
    end
  end

  // A button only arms once a genuinely released sample has passed the synchroniser,
  // so a button held through reset cannot fire until it is released and pressed again.
  always_comb begin
    settle_done_s = (settle_q == 2'd2);
    settle_d      = settle_done_s ? settle_q : settle_q + 2'd1;
    armed_d       = armed_q | (settle_done_s ? sync2_q : 3'b000);
    press_s       = ~sync2_q & hist_q & armed_q;
  end

  assign tick_s = (presc_q == PRESC_LAST);

  // Tick prescaler and sweep pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= {CW{1'b0}};
      sweep_q <= 1'b0;
      p_q     <= {PW{1'b0}};
    end else begin
      presc_q <= tick_s ? {CW{1'b0}} : presc_q + CW'(1);
      if (tick_s) begin
        sweep_q <= 1'b1;
        p_q     <= {PW{1'b0}};
      end else if (sweep_q) begin
        sweep_q <= (p_q != P_LAST);
        p_q     <= (p_q == P_LAST) ? {PW{1'b0}} : p_q + PW'(1);
      end else begin
        sweep_q <= 1'b0;
        p_q     <= p_q;
      end
    end
  end

  // Channel state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= {WIDTH{1'b0}};
        st_q[c]  <= IDLE;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_d[c];
        st_q[c]  <= st_d[c];
      end
    end
  end

  assign load_cs_s = WIDTH'(load_val) * CS_PER_S;

  // Channel next state: sweep decrement first, then a command on sel overrides it
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      st_d[c]  = st_q[c];
      if (sweep_q && (p_q == PW'(c)) && (st_q[c] == RUN)) begin
        if (cnt_q[c] > WIDTH'(1)) begin
          cnt_d[c] = cnt_q[c] - WIDTH'(1);
        end else begin
          cnt_d[c] = {WIDTH{1'b0}};
          st_d[c]  = EXPIRED;
        end
      end else begin
        cnt_d[c] = cnt_q[c];
      end
    end
    if (press_s[B_CLR]) begin
      cnt_d[sel] = {WIDTH{1'b0}};
      st_d[sel]  = IDLE;
    end else if (press_s[B_LD]) begin
      cnt_d[sel] = load_cs_s;
      st_d[sel]  = IDLE;
    end else if (press_s[B_SS]) begin
      cnt_d[sel] = cnt_q[sel];
      case (st_q[sel])
        IDLE:    st_d[sel] = (cnt_q[sel] != {WIDTH{1'b0}}) ? RUN : IDLE;
        RUN:     st_d[sel] = PAUSE;
        PAUSE:   st_d[sel] = RUN;
        EXPIRED: st_d[sel] = EXPIRED;
        default: st_d[sel] = IDLE;
      endcase
    end else begin
      cnt_d[sel] = cnt_d[sel];
    end
  end

  // Output decode from current channel state
  always_comb begin
    disp_value_d = cnt_q[sel];
    disp_flash_d = (st_q[sel] == PAUSE) || (st_q[sel] == EXPIRED);
    for (int c = 0; c < NUM_CH; c++) begin
      running_d[c] = (st_q[c] == RUN);
      expired_d[c] = (st_q[c] == EXPIRED);
    end
    buzzer_on_d = |expired_d;
  end

  // Output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_value_q <= {WIDTH{1'b0}};
      disp_flash_q <= 1'b0;
      buzzer_on_q  <= 1'b0;
      running_q    <= {NUM_CH{1'b0}};
      expired_q    <= {NUM_CH{1'b0}};
    end else begin
      disp_value_q <= disp_value_d;
      disp_flash_q <= disp_flash_d;
      buzzer_on_q  <= buzzer_on_d;
      running_q    <= running_d;
      expired_q    <= expired_d;
    end
  end

  assign disp_value = disp_value_q;
  assign disp_flash = disp_flash_q;
  assign buzzer_on  = buzzer_on_q;
  assign running    = running_q;
  assign expired    = expired_q;

endmodule

// File: tb/tb_alarm_channel_scheduler.sv
// Randomised and directed bench for alarm_channel_scheduler, checked every cycle against
// an edge-counting behavioural model of channels, ticks and button presses.
module tb_alarm_channel_scheduler;
  localparam int NCH     = 4;
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int W       = 16;
  localparam int PRESC   = CLK_HZ / TICK_HZ;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    sel = 2'd0;
  logic [8:0]    load_val = 9'd0;
  logic          btn_load = 1'b1, btn_startstop = 1'b1, btn_clear = 1'b1;
  logic [W-1:0]  disp_value;
  logic          disp_flash, buzzer_on;
  logic [NCH-1:0] running, expired;

  int n_checks = 0;
  int n_errors = 0;

  // model: states 0 IDLE, 1 RUN, 2 PAUSE, 3 EXPIRED; edge_n counts edges since reset release
  int m_cnt [NCH];
  int m_st  [NCH];
  int edge_n;
  bit hist [3][3];
  logic [W-1:0]   e_disp;
  logic           e_flash, e_buzz;
  logic [NCH-1:0] e_run, e_exp;

  always #5 clk = ~clk;

  alarm_channel_scheduler #(.NUM_CH(NCH), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .sel(sel), .load_val(load_val),
    .btn_load(btn_load), .btn_startstop(btn_startstop), .btn_clear(btn_clear),
    .disp_value(disp_value), .disp_flash(disp_flash), .buzzer_on(buzzer_on),
    .running(running), .expired(expired)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0;
      m_st[c]  = 0;
    end
    edge_n = 0;
    for (int b = 0; b < 3; b++) for (int j = 0; j < 3; j++) hist[b][j] = 1'b1;
  endtask

  // one rising edge of the model; buttons index 0 clear, 1 load, 2 startstop
  task automatic model_step();
    bit pins [3];
    bit pr [3];
    int s, pre_st, pre_cnt, ph;
    edge_n++;
    pins[0] = btn_clear; pins[1] = btn_load; pins[2] = btn_startstop;
    for (int b = 0; b < 3; b++) begin
      // press seen now iff pin was low two edges ago and high three edges ago
      pr[b] = (edge_n >= 4) && (hist[b][1] == 1'b0) && (hist[b][2] == 1'b1);
      hist[b][2] = hist[b][1];
      hist[b][1] = hist[b][0];
      hist[b][0] = pins[b];
    end
    s = int'(sel);
    pre_st  = m_st[s];
    pre_cnt = m_cnt[s];
    ph = (edge_n - 1) % PRESC;
    if ((edge_n - 1 >= PRESC) && (ph < NCH) && (m_st[ph] == 1)) begin
      if (m_cnt[ph] > 1) m_cnt[ph] = m_cnt[ph] - 1;
      else begin
        m_cnt[ph] = 0;
        m_st[ph]  = 3;
      end
    end
    if (pr[0]) begin
      m_cnt[s] = 0; m_st[s] = 0;
    end else if (pr[1]) begin
      m_cnt[s] = int'(load_val) * 100; m_st[s] = 0;
    end else if (pr[2]) begin
      m_cnt[s] = pre_cnt;
      m_st[s]  = pre_st;
      if (pre_st == 0 && pre_cnt != 0) m_st[s] = 1;
      else if (pre_st == 1) m_st[s] = 2;
      else if (pre_st == 2) m_st[s] = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      e_disp  = W'(m_cnt[sel]);
      e_flash = (m_st[sel] == 2) || (m_st[sel] == 3);
      for (int c = 0; c < NCH; c++) begin
        e_run[c] = (m_st[c] == 1);
        e_exp[c] = (m_st[c] == 3);
      end
      e_buzz = |e_exp;
      model_step();
    end else begin
      e_disp = '0; e_flash = 1'b0; e_buzz = 1'b0; e_run = '0; e_exp = '0;
      model_reset();
    end
    @(negedge clk);
    chk_eq("disp_value", 32'(disp_value), 32'(e_disp));
    chk_eq("disp_flash", 32'(disp_flash), 32'(e_flash));
    chk_eq("buzzer_on",  32'(buzzer_on),  32'(e_buzz));
    chk_eq("running",    32'(running),    32'(e_run));
    chk_eq("expired",    32'(expired),    32'(e_exp));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  // mask bit 2 clear, bit 1 load, bit 0 startstop
  task automatic press_btns(input logic [2:0] mask, input int hold);
    btn_clear = ~mask[2]; btn_load = ~mask[1]; btn_startstop = ~mask[0];
    idle(hold);
    btn_clear = 1'b1; btn_load = 1'b1; btn_startstop = 1'b1;
  endtask

  task automatic cmd(input int ch, input int val, input logic [2:0] mask);
    sel = 2'(ch);
    load_val = 9'(val);
    press_btns(mask, 2);
    idle(3);
  endtask

  task automatic chk_async_reset(input string tag);
    #1;
    chk_eq(tag, 32'({disp_value, disp_flash, buzzer_on, running, expired}), 32'd0);
  endtask

  initial begin
    int act, hold, gap;
    model_reset();
    #2 reset = 1'b0;
    chk_async_reset("reset_async");
    idle(3);
    @(negedge clk);
    reset = 1'b1;
    idle(100);

    // load and run channel 1
    cmd(1, 2, 3'b010);
    chk_eq("load_disp200", 32'(disp_value), 32'd200);
    cmd(1, 0, 3'b001);
    chk_eq("run_ch1", 32'(running), 32'b0010);
    idle(2100);
    chk_eq("ch1_expired", 32'(expired), 32'b0010);
    chk_eq("ch1_buzzer", 32'(buzzer_on), 32'd1);
    chk_eq("ch1_flash", 32'(disp_flash), 32'd1);
    chk_eq("ch1_not_running", 32'(running), 32'b0000);

    // pause / resume on channel 0
    cmd(0, 5, 3'b010);
    cmd(0, 5, 3'b001);
    idle(30);
    cmd(0, 5, 3'b001);
    idle(60);
    chk_eq("pause_flash", 32'(disp_flash), 32'd1);
    chk_eq("pause_running", 32'(running), 32'b0000);
    cmd(0, 5, 3'b001);
    idle(20);
    chk_eq("resume_flash", 32'(disp_flash), 32'd0);
    chk_eq("resume_running", 32'(running), 32'b0001);

    // shared decrementer: channels loaded 1..4 s and all started
    for (int c = 0; c < NCH; c++) cmd(c, c + 1, 3'b010);
    for (int c = 0; c < NCH; c++) cmd(c, 0, 3'b001);
    idle(4200);
    chk_eq("all_expired", 32'(expired), 32'b1111);

    // load and clear together: clear wins
    cmd(3, 7, 3'b110);
    chk_eq("ld_clr_disp", 32'(disp_value), 32'd0);
    chk_eq("ld_clr_flash", 32'(disp_flash), 32'd0);

    // clear on channel 2 in the very cycle the sweep visits it
    cmd(2, 3, 3'b010);
    cmd(2, 3, 3'b001);
    idle(25);
    for (int g = 0; g < PRESC && (edge_n % PRESC) != 0; g++) cycle();
    chk_eq("align_sweep", 32'(edge_n % PRESC), 32'd0);
    press_btns(3'b100, 2);
    idle(3);
    chk_eq("coll_clr_disp", 32'(disp_value), 32'd0);
    chk_eq("coll_clr_running", 32'(running[2]), 32'd0);

    // ignored startstop commands
    cmd(2, 0, 3'b001);
    chk_eq("ss_idle0_running", 32'(running), 32'b0000);
    chk_eq("ss_idle0_flash", 32'(disp_flash), 32'd0);
    cmd(0, 0, 3'b001);
    chk_eq("ss_exp_expired", 32'(expired), 32'b0011);
    chk_eq("ss_exp_buzzer", 32'(buzzer_on), 32'd1);
    cmd(0, 0, 3'b100);
    chk_eq("clr0_buzzer", 32'(buzzer_on), 32'd1);
    cmd(1, 0, 3'b100);
    chk_eq("clr1_buzzer", 32'(buzzer_on), 32'd0);

    // button held through reset must not fire
    sel = 2'd0; load_val = 9'd9; btn_load = 1'b0;
    reset = 1'b0;
    chk_async_reset("held_reset_async");
    idle(3);
    reset = 1'b1;
    idle(20);
    chk_eq("held_no_press", 32'(disp_value), 32'd0);
    btn_load = 1'b1;
    idle(5);
    cmd(0, 9, 3'b010);
    chk_eq("repress_load", 32'(disp_value), 32'd900);

    // randomised command stream
    for (int it = 0; it < 200; it++) begin
      sel = 2'($urandom_range(0, 3));
      load_val = 9'($urandom_range(0, 3));
      act  = $urandom_range(0, 19);
      hold = $urandom_range(1, 3);
      case (act)
        0, 1, 2, 3:            press_btns(3'b010, hold);
        4, 5, 6, 7, 8, 9, 10:  press_btns(3'b001, hold);
        11, 12:                press_btns(3'b100, hold);
        13:                    press_btns(3'b110, hold);
        14:                    press_btns(3'b011, hold);
        15:                    press_btns(3'b111, hold);
        16: begin
          reset = 1'b0;
          chk_async_reset("rand_reset_async");
          idle(2);
          reset = 1'b1;
        end
        default:               idle(hold);
      endcase
      gap = $urandom_range(0, 40);
      idle(gap);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/alarm_channel_scheduler.md
Name: alarm_channel_scheduler

Overview:
- Time-multiplexes one shared centisecond decrementer across NUM_CH independent countdown alarm channels.
- Applies user button commands to the channel chosen by the switches.
- Arbitrates the single 7-segment display value, flash enable and buzzer among the channels.
- Sits between the board buttons/switches and the display driver/buzzer; replaces the single-timer controller when multiple alarms are needed.

Parameters:
- NUM_CH, 4, number of alarm channels (power of 2, 2..8).
- CLK_HZ, 50_000_000, input clock frequency.
- TICK_HZ, 100, decrement rate (1 tick = 1 centisecond).
- WIDTH, 16, count width in centiseconds.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- sel  in  $clog2(NUM_CH)  channel targeted by commands and shown on the display.
- load_val  in  9  load value in seconds (0..511).
- btn_load  in  1  raw button, active-low.
- btn_startstop  in  1  raw button, active-low.
- btn_clear  in  1  raw button, active-low.
- disp_value  out  WIDTH  count of channel sel, in centiseconds.
- disp_flash  out  1  selected channel is PAUSE or EXPIRED.
- buzzer_on  out  1  any channel EXPIRED.
- running  out  NUM_CH  per-channel RUN flag.
- expired  out  NUM_CH  per-channel EXPIRED flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - All channel counts = 0, all states IDLE.
  - Prescaler = 0, sweep idle.
  - Button sync/history flops = 1 (released).
  - All outputs = 0.
- Button path, per button:
  - 2-flop synchroniser, then a history flop.
  - press = (sync==0 && history==1); exactly one 1-cycle pulse per falling edge; holding the button gives no repeat.
  - A pin sampled low at edge k updates channel state at edge k+2; registered outputs change at edge k+3.
- Per-channel FSM: IDLE, RUN, PAUSE, EXPIRED.
  - Load: any state -> IDLE, count = load_val*100. Multiply at ≥16 bits; 511*100 = 51100 fits.
  - Clear: any state -> IDLE, count = 0.
  - Startstop:
    - IDLE with count≠0 -> RUN.
    - IDLE with count==0: ignored.
    - RUN -> PAUSE.
    - PAUSE -> RUN.
    - EXPIRED: ignored; exit only via load or clear.
  - Same-cycle priority: clear > load > startstop. Only the highest is applied.
  - Commands act only on channel sel as sampled in the cycle the press pulse is high.
- Tick prescaler:
  - Counts 0..CLK_HZ/TICK_HZ-1; tick pulse on terminal count, then wraps to 0.
  - Constraint: CLK_HZ/TICK_HZ ≥ NUM_CH+1, checked by elaboration-time assertion.
- Sweep scheduler:
  - A tick starts a sweep; pointer p = 0..NUM_CH-1, one channel per cycle, then the sweep goes idle.
  - Channel p in RUN:
    - count>1 -> count-1.
    - count==1 -> count 0, state EXPIRED.
  - Channels not in RUN are untouched.
  - A channel in RUN with count==0 cannot occur and needs no handling.
  - Command and sweep on the same channel in the same cycle: the command result is written and that channel's decrement is dropped for this tick.
  - Commands on other channels proceed in parallel.
  - Every running channel is decremented exactly once per tick.
- Outputs, registered every cycle:
  - disp_value = count[sel]; a sel change is shown 1 cycle later.
  - disp_flash = state[sel] ∈ {PAUSE, EXPIRED}.
  - buzzer_on = OR of expired.
  - running and expired are per-channel state decodes.
- Reset mid-sweep or mid-press: all of the above are cleared immediately. A button held through reset deassertion produces no press until it is released and pressed again.

Test Plan:
Bench parameters: CLK_HZ=1000, TICK_HZ=100, so one tick every 10 cycles.
- Reset: hold reset=0, buttons=1 -> all outputs 0; after release with no presses, outputs stay 0 for 100 cycles.
- Load and run: sel=1, load_val=2, press load -> disp_value=200 at press+3. Press startstop -> running=4'b0010; disp_value decrements by 1 per 10 cycles. At 0: expired[1]=1, buzzer_on=1, disp_flash=1, running[1]=0.
- Pause/resume: channel 0 loaded 5 and running. Press startstop -> disp_value frozen and disp_flash=1 for ≥50 cycles. Press again -> decrement resumes, disp_flash=0.
- Shared decrementer: channels 0..3 loaded 1,2,3,4 and all started -> each expired bit sets at 100, 200, 300, 400 ticks respectively; no channel is skipped or double-decremented (checked against a reference model).
- Priority and collision:
  - Press load and clear in the same cycle -> count=0, IDLE.
  - Press clear on channel 2 in the cycle sweep p=2 -> count=0, no underflow or wrap to 0xFFFF.
- Ignored commands:
  - Startstop on an IDLE channel with count 0 -> stays IDLE.
  - Startstop on an EXPIRED channel -> stays EXPIRED, buzzer_on stays 1; only a later clear drops buzzer_on to 0.
